addsub_seq: RTL and testbench

- Multi-cycle, digit-serial ARMv4 add/subtract unit with start/done handshake and registered NZCV flags.
- Processes an N-bit operation D bits per cycle, LSB digit first, using a registered carry chain.
- Sits beside the single-cycle ALU datapath and serves all eight ARM add/subtract/compare ops, including carry-in variants.
- Trades latency for area in wide configurations.

---
 rtl/addsub_seq_pkg.sv | 34 +++
 rtl/addsub_digit.sv | 29 ++
 rtl/addsub_seq.sv | 146 ++++++++++++++
 tb/tb_addsub_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the digit-serial ARM add/subtract unit.
package addsub_seq_pkg;

  // ARM add/subtract/compare operation codes
  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC = 3'd1,
    SUB = 3'd2,
    SBC = 3'd3,
    RSB = 3'd4,
    RSC = 3'd5,
    CMP = 3'd6,
    CMN = 3'd7
  } op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the FLAGS vector
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Compares only set flags; every other op writes the result register
  function automatic logic writes_result(op_t o);
    return !(o == CMP || o == CMN);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational D-bit ripple slice: sum, carry out, and the carry into the
// slice MSB (used for overflow on the most significant digit).
module addsub_digit #(
  parameter int D = 8
) (
  input  logic [D-1:0] x_d,
  input  logic [D-1:0] y_d,
  input  logic         cin,
  output logic [D-1:0] sum_d,
  output logic         cout,
  output logic         c_msb
);

  logic carry;

  // Ripple the carry through the digit, remembering the carry into bit D-1
  always_comb begin
    carry = cin;
    c_msb = cin;
    sum_d = '0;
    for (int i = 0; i < D; i++) begin
      if (i == D - 1) c_msb = carry;
      sum_d[i] = x_d[i] ^ y_d[i] ^ carry;
      carry    = (x_d[i] & y_d[i]) | (carry & (x_d[i] ^ y_d[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial ARMv4 add/subtract unit with start/done handshake and
// registered NZCV flags. Processes N bits, D bits per cycle, LSB first.
// Optional build macro ADDSUB_SEQ_SET_FLAGS_EN: when defined, FLAGS are only
// updated if the latched set_flags bit is 1 (CMP/CMN always update).
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  input  logic         set_flags,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] s,
  output logic [3:0]   FLAGS
);

  localparam int STEPS = N / D;
  localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t         state;
  op_t            op_reg;
  logic           sf_reg;
  logic [N-1:0]   x_reg;
  logic [N-1:0]   y_reg;
  logic [N-1:0]   res;
  logic           c_reg;
  logic           zero_acc;
  logic [IW-1:0]  idx;

  logic [N-1:0]   map_x;
  logic [N-1:0]   map_y;
  logic           map_c;
  logic [D-1:0]   sum_d;
  logic           cout;
  logic           c_msb;
  logic [N-1:0]   next_res;
  logic           flag_upd;

  addsub_digit #(.D(D)) u_digit (
    .x_d   (x_reg[D-1:0]),
    .y_d   (y_reg[D-1:0]),
    .cin   (c_reg),
    .sum_d (sum_d),
    .cout  (cout),
    .c_msb (c_msb)
  );

  // New digit enters at the top of the result shift register
  assign next_res = (res >> D) | (N'(sum_d) << (N - D));

`ifdef ADDSUB_SEQ_SET_FLAGS_EN
  assign flag_upd = sf_reg | (op_reg == CMP) | (op_reg == CMN);
`else
  logic unused_sf;
  assign unused_sf = sf_reg;
  assign flag_upd  = 1'b1;
`endif

  // Map the requested op onto a single x + y + c addition
  always_comb begin
    map_x = a;
    map_y = b;
    map_c = 1'b0;
    case (op_t'(op))
      ADD, CMN: map_c = 1'b0;
      ADC:      map_c = carry_in;
      SUB, CMP: begin map_y = ~b; map_c = 1'b1;     end
      SBC:      begin map_y = ~b; map_c = carry_in; end
      RSB:      begin map_x = b; map_y = ~a; map_c = 1'b1;     end
      RSC:      begin map_x = b; map_y = ~a; map_c = carry_in; end
      default:  map_c = 1'b0;
    endcase
  end

  // Sequencer: accept, step through the digits, commit result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_reg   <= ADD;
      sf_reg   <= 1'b0;
      x_reg    <= '0;
      y_reg    <= '0;
      res      <= '0;
      c_reg    <= 1'b0;
      zero_acc <= 1'b0;
      idx      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      s        <= '0;
      FLAGS    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_reg    <= map_x;
            y_reg    <= map_y;
            c_reg    <= map_c;
            op_reg   <= op_t'(op);
            sf_reg   <= set_flags;
            zero_acc <= 1'b1;
            idx      <= '0;
            state    <= RUN;
            ready    <= 1'b0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        RUN: begin
          x_reg    <= x_reg >> D;
          y_reg    <= y_reg >> D;
          c_reg    <= cout;
          res      <= next_res;
          zero_acc <= zero_acc & (sum_d == '0);
          idx      <= idx + 1'b1;
          if (idx == IW'(STEPS - 1)) begin
            if (writes_result(op_reg)) s <= next_res;
            if (flag_upd) begin
              FLAGS[FLAG_N] <= sum_d[D-1];
              FLAGS[FLAG_Z] <= zero_acc & (sum_d == '0);
              FLAGS[FLAG_C] <= cout;
              FLAGS[FLAG_V] <= cout ^ c_msb;
            end
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (N=32, D=8): directed steps with a
// scoreboard of expected results produced by a reference model.
module tb_addsub_seq;
  import addsub_seq_pkg::*;

  localparam int N     = 32;
  localparam int D     = 8;
  localparam int STEPS = N / D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          carry_in = 1'b0;
  logic          set_flags = 1'b0;
  logic          ready;
  logic          done;
  logic [N-1:0]  s;
  logic [3:0]    FLAGS;

  typedef struct {
    logic [31:0] s;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_s = '0;
  logic [3:0]  m_flags = '0;
  int          tests = 0;
  int          fails = 0;

  addsub_seq #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .set_flags (set_flags),
    .ready     (ready),
    .done      (done),
    .s         (s),
    .FLAGS     (FLAGS)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the ARM operand mapping
  task automatic modelOp(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic isf);
    logic [31:0] x, y, r;
    logic        c, upd;
    logic [32:0] sum;
    exp_t        e;
    case (o)
      3'd0, 3'd7: begin x = ia; y = ib;  c = 1'b0; end
      3'd1:       begin x = ia; y = ib;  c = ic;   end
      3'd2, 3'd6: begin x = ia; y = ~ib; c = 1'b1; end
      3'd3:       begin x = ia; y = ~ib; c = ic;   end
      3'd4:       begin x = ib; y = ~ia; c = 1'b1; end
      default:    begin x = ib; y = ~ia; c = ic;   end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, c};
    r   = sum[31:0];
    if (o != 3'd6 && o != 3'd7) m_s = r;
`ifdef ADDSUB_SEQ_SET_FLAGS_EN
    upd = isf || (o == 3'd6) || (o == 3'd7);
`else
    upd = 1'b1 | isf;
`endif
    if (upd) m_flags = {(x[31] == y[31]) && (r[31] != x[31]), sum[32], r == 32'd0, r[31]};
    e.s     = m_s;
    e.flags = m_flags;
    sb.push_back(e);
  endtask

  // Drive one request for a single accept edge; optionally keep start high
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                               input logic ic, input logic isf, input logic hold);
    @(negedge clk);
    op = o; a = ia; b = ib; carry_in = ic; set_flags = isf; start = 1'b1;
    modelOp(o, ia, ib, ic, isf);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Change operands while start stays high (next request for the DONE cycle)
  task automatic loadNext(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic ic, input logic isf);
    op = o; a = ia; b = ib; carry_in = ic; set_flags = isf;
    modelOp(o, ia, ib, ic, isf);
  endtask

  // Wait (bounded) for done, check latency in negedges, then pop and compare
  task automatic checkOutput(input string tag, input int lat);
    int   n;
    logic seen;
    exp_t e;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    compare({tag, "_latency"}, n, lat);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      compare({tag, "_s"}, s, e.s);
      compare({tag, "_flags"}, {28'd0, FLAGS}, {28'd0, e.flags});
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  // Count done pulses over a window where none are allowed
  task automatic checkQuiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    compare(tag, pulses, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    compare("reset_ready", {31'd0, ready}, 32'd1);
    compare("reset_done", {31'd0, done}, 32'd0);
    compare("reset_s", s, 32'd0);
    compare("reset_flags", {28'd0, FLAGS}, 32'd0);
    rst_n = 1'b1;

    // SUB 5-3: C set, not borrow
    applyStimulus(3'd2, 32'd5, 32'd3, 1'b0, 1'b1, 1'b0);
    compare("run_ready_low", {31'd0, ready}, 32'd0);
    checkOutput("sub_5_3", STEPS + 1);
    compare("sub_5_3_const_s", s, 32'h0000_0002);
    compare("sub_5_3_const_flags", {28'd0, FLAGS}, 32'b0100);
    @(negedge clk);
    compare("done_one_cycle", {31'd0, done}, 32'd0);

    // SUB 3-5 and RSB with swapped operands give the same answer
    applyStimulus(3'd2, 32'd3, 32'd5, 1'b0, 1'b1, 1'b0);
    checkOutput("sub_3_5", STEPS + 1);
    compare("sub_3_5_const_s", s, 32'hFFFF_FFFE);
    compare("sub_3_5_const_flags", {28'd0, FLAGS}, 32'b0001);
    applyStimulus(3'd4, 32'd5, 32'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("rsb_5_3", STEPS + 1);
    compare("rsb_5_3_const_flags", {28'd0, FLAGS}, 32'b0001);

    // Signed overflow, then unsigned wrap to zero
    applyStimulus(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("add_ovf", STEPS + 1);
    compare("add_ovf_const_flags", {28'd0, FLAGS}, 32'b1001);
    applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("add_wrap", STEPS + 1);
    compare("add_wrap_const_flags", {28'd0, FLAGS}, 32'b0110);

    // SBC with borrow-in, then CMP with an ignored mid-run start pulse
    applyStimulus(3'd3, 32'd10, 32'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("sbc", STEPS + 1);
    compare("sbc_const_s", s, 32'd6);
    applyStimulus(3'd6, 32'd7, 32'd7, 1'b0, 1'b1, 1'b0);
    op = 3'd0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("cmp", STEPS);
    compare("cmp_keeps_s", s, 32'd6);
    compare("cmp_const_flags", {28'd0, FLAGS}, 32'b0110);
    checkQuiet("cmp_single_done", STEPS + 2);

    // Back-to-back: start held high through DONE
    applyStimulus(3'd1, 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    loadNext(3'd5, 32'd1, 32'd0, 1'b0, 1'b1);
    checkOutput("b2b_first", STEPS + 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_second", STEPS + 1);

    // Reset asserted during RUN step 2 discards the operation
    applyStimulus(3'd0, 32'h11, 32'h22, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("midrst_s", s, 32'd0);
    compare("midrst_flags", {28'd0, FLAGS}, 32'd0);
    compare("midrst_ready", {31'd0, ready}, 32'd1);
    compare("midrst_done", {31'd0, done}, 32'd0);
    void'(sb.pop_back());
    m_s = '0;
    m_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    checkQuiet("midrst_no_done", STEPS + 2);

    // set_flags=0 after a flag-setting op (flags hold only with the feature)
    applyStimulus(3'd2, 32'd3, 32'd5, 1'b0, 1'b1, 1'b0);
    checkOutput("sf_setup", STEPS + 1);
    applyStimulus(3'd0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("sf_add", STEPS + 1);
    compare("sf_add_const_s", s, 32'd2);
    applyStimulus(3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("cmn_sf0", STEPS + 1);
    compare("cmn_sf0_const_flags", {28'd0, FLAGS}, 32'b0110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
